// File: rtl/clock_phase_gen.sv
// Divides MasterClock into a 50%-duty clkOut with rise/fall strobes, a stop/start
// handshake that parks clkOut low, and an edge-strobe synchroniser for extClk.
//
// state   | meaning
// RUN     | dividing normally, clkOut toggles every divReg cycles
// DRAIN   | stop requested while high; finish the high phase, then stop
// STOPPED | clkOut parked low, cnt held at 0, stopAck high
module clock_phase_gen #(
  parameter int DIV_WIDTH   = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 MasterClock,
  input  logic                 resetL,
  input  logic                 divLoad,
  input  logic [DIV_WIDTH-1:0] divValue,
  input  logic                 stopReq,
  input  logic                 extClk,
  output logic                 clkOut,
  output logic                 clkRise,
  output logic                 clkFall,
  output logic                 stopAck,
  output logic                 extRise,
  output logic                 extFall
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] STOPPED = 2'd2;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  logic [1:0]           state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] divReg;
  logic [DIV_WIDTH-1:0] pendDiv;
  logic                 pendValid;
  logic                 s1, s2, s3;

  logic                 termCnt;
  logic                 fallEdge;
  logic                 applyPend;
  logic [DIV_WIDTH-1:0] loadVal;

  assign termCnt = (cnt == divReg - ONE);
  assign loadVal = (divValue == '0) ? ONE : divValue;

  always_comb begin
    fallEdge = 1'b0;
    if (state == RUN || state == DRAIN) fallEdge = termCnt && clkOut;
  end

  // A pending divide only takes effect at a falling toggle (or while stopped),
  // so every new period begins with a full low phase.
  assign applyPend = pendValid && (fallEdge || state == STOPPED);

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      state     <= RUN;
      cnt       <= '0;
      divReg    <= DEF;
      pendDiv   <= DEF;
      pendValid <= 1'b0;
      clkOut    <= 1'b0;
      clkRise   <= 1'b0;
      clkFall   <= 1'b0;
      stopAck   <= 1'b0;
    end else begin
      clkRise <= 1'b0;
      clkFall <= 1'b0;

      if (divLoad) begin
        pendDiv   <= loadVal;
        pendValid <= 1'b1;
      end else if (applyPend) begin
        pendValid <= 1'b0;
      end
      if (applyPend) divReg <= pendDiv;

      case (state)
        RUN: begin
          if (stopReq && !clkOut) begin
            state   <= STOPPED;
            cnt     <= '0;
            stopAck <= 1'b1;
          end else if (termCnt) begin
            clkOut  <= !clkOut;
            cnt     <= '0;
            clkRise <= !clkOut;
            clkFall <= clkOut;
            // Stop requested exactly as the high phase ends: no drain needed.
            if (stopReq) begin
              state   <= STOPPED;
              stopAck <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
            if (stopReq) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (termCnt) begin
            clkOut  <= 1'b0;
            cnt     <= '0;
            clkFall <= 1'b1;
            state   <= STOPPED;
            stopAck <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        STOPPED: begin
          clkOut <= 1'b0;
          cnt    <= '0;
          if (!stopReq) begin
            state   <= RUN;
            stopAck <= 1'b0;
          end
        end

        default: begin
          state   <= RUN;
          cnt     <= '0;
          clkOut  <= 1'b0;
          stopAck <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      extRise <= 1'b0;
      extFall <= 1'b0;
    end else begin
      s1      <= extClk;
      s2      <= s1;
      s3      <= s2;
      extRise <= s2 & ~s3;
      extFall <= ~s2 & s3;
    end
  end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: divide timing, divide reload, stop/drain
// handshake, extClk edge strobes and mid-operation reset.
module tb_clock_phase_gen;

  logic       MasterClock = 1'b0;
  logic       resetL = 1'b0;
  logic       divLoad = 1'b0;
  logic [3:0] divValue = 4'd0;
  logic       stopReq = 1'b0;
  logic       extClk = 1'b0;
  logic       clkOut, clkRise, clkFall, stopAck, extRise, extFall;

  int total = 0;
  int bad = 0;

  clock_phase_gen #(.DIV_WIDTH(4), .DEFAULT_DIV(2)) dut (
    .MasterClock(MasterClock),
    .resetL(resetL),
    .divLoad(divLoad),
    .divValue(divValue),
    .stopReq(stopReq),
    .extClk(extClk),
    .clkOut(clkOut),
    .clkRise(clkRise),
    .clkFall(clkFall),
    .stopAck(stopAck),
    .extRise(extRise),
    .extFall(extFall)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge MasterClock);
    #1;
  endtask

  // Starting just after clkOut became lvl: it must hold for n-1 edges and toggle on the nth.
  task automatic runPhase(input int n, input logic lvl);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i < n) begin
        check("phaseHold", clkOut, lvl);
        check("phaseNoStrobe", clkRise | clkFall, 0);
      end else begin
        check("phaseToggle", clkOut, !lvl);
        check("phaseRise", clkRise, !lvl);
        check("phaseFall", clkFall, lvl);
      end
    end
  endtask

  initial begin
    int acc;
    int rises;
    int falls;
    logic expOut;

    #12;
    check("rstClkOut", clkOut, 0);
    check("rstStrobes", {clkRise, clkFall, stopAck, extRise, extFall}, 0);
    resetL = 1'b1;

    // DEFAULT_DIV=2: rise after edge 2, fall after edge 4, period 4
    for (int k = 1; k <= 12; k++) begin
      tick();
      expOut = (k % 4 == 2) || (k % 4 == 3);
      check("defClkOut", clkOut, expOut);
      check("defRise", clkRise, (k % 4 == 2));
      check("defFall", clkFall, (k % 4 == 0));
      check("defStopAck", stopAck, 0);
    end

    // load 5 during a high phase of N=2
    runPhase(2, 1'b0);
    divLoad = 1'b1; divValue = 4'd5;
    tick();
    divLoad = 1'b0;
    check("load5High", clkOut, 1);
    runPhase(1, 1'b1);
    runPhase(5, 1'b0);
    runPhase(5, 1'b1);
    runPhase(5, 1'b0);

    // load 0 -> treated as 1
    divLoad = 1'b1; divValue = 4'd0;
    tick();
    divLoad = 1'b0;
    check("load0High", clkOut, 1);
    runPhase(4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      runPhase(1, 1'b0);
      runPhase(1, 1'b1);
    end

    // switch to N=3 from N=1
    divLoad = 1'b1; divValue = 4'd3;
    tick();
    divLoad = 1'b0;
    check("n1Rise", clkRise, 1);
    tick();
    check("n1Fall", clkOut, 0);
    runPhase(3, 1'b0);

    // stop while high with cnt=0: drains the remaining high phase
    stopReq = 1'b1;
    tick();
    check("drainHigh1", clkOut, 1);
    check("drainAck1", stopAck, 0);
    tick();
    check("drainHigh2", clkOut, 1);
    check("drainAck2", stopAck, 0);
    tick();
    check("drainFell", clkOut, 0);
    check("drainAckSet", stopAck, 1);
    tick();
    tick();
    check("stoppedLow", clkOut, 0);
    check("stoppedAck", stopAck, 1);
    stopReq = 1'b0;
    tick();
    check("restartAck", stopAck, 0);
    check("restartLow", clkOut, 0);
    runPhase(3, 1'b0);
    runPhase(3, 1'b1);

    // stop while low: ack after one edge, nothing moves for 20 cycles
    stopReq = 1'b1;
    tick();
    check("lowStopAck", stopAck, 1);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin divLoad = 1'b1; divValue = 4'd4; end
      tick();
      divLoad = 1'b0;
      acc += int'(clkOut | clkRise | clkFall);
    end
    check("stoppedQuiet", acc, 0);
    check("stoppedAckHeld", stopAck, 1);
    stopReq = 1'b0;
    tick();
    check("restart2Ack", stopAck, 0);
    runPhase(4, 1'b0);

    // stopReq dropped during DRAIN: stop still completes
    stopReq = 1'b1;
    tick();
    check("drop1", clkOut, 1);
    stopReq = 1'b0;
    tick();
    check("drop2", clkOut, 1);
    tick();
    check("drop3", clkOut, 1);
    tick();
    check("dropFell", clkOut, 0);
    check("dropAck", stopAck, 1);
    tick();
    check("dropResume", stopAck, 0);
    runPhase(4, 1'b0);

    // extClk rise then fall, strobe on the 3rd edge after each change
    extClk = 1'b1;
    #3;
    tick(); check("extR1", extRise, 0);
    tick(); check("extR2", extRise, 0);
    tick(); check("extR3", extRise, 1); check("extR3f", extFall, 0);
    tick(); check("extR4", extRise, 0);
    for (int i = 0; i < 6; i++) tick();
    extClk = 1'b0;
    tick(); check("extF1", extFall, 0);
    tick(); check("extF2", extFall, 0);
    tick(); check("extF3", extFall, 1); check("extF3r", extRise, 0);
    tick(); check("extF4", extFall, 0);

    // two single-cycle pulses: one rise and one fall strobe each
    rises = 0; falls = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) extClk = 1'b1;
      if (i == 1 || i == 9) extClk = 1'b0;
      tick();
      rises += int'(extRise);
      falls += int'(extFall);
    end
    check("pulseRises", rises, 2);
    check("pulseFalls", falls, 2);

    // reset during DRAIN with a pending load
    acc = 0;
    while (!clkRise && acc < 12) begin tick(); acc++; end
    check("findRise", clkRise, 1);
    stopReq = 1'b1; divLoad = 1'b1; divValue = 4'd7;
    tick();
    divLoad = 1'b0;
    check("preRstHigh", clkOut, 1);
    #2;
    resetL = 1'b0;
    #1;
    check("midRstOuts", {clkOut, clkRise, clkFall, stopAck, extRise, extFall}, 0);
    stopReq = 1'b0;
    #3;
    resetL = 1'b1;
    runPhase(2, 1'b0);
    runPhase(2, 1'b1);
    runPhase(2, 1'b0);
    check("postRstAck", stopAck, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
